// File: rtl/rock_pkg.sv
// Shared types and defaults for the rocking controller.
package rock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DECIDE  = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  typedef enum logic {
    AXIS_A = 1'b0,
    AXIS_F = 1'b1
  } axis_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  localparam int unsigned CALM_THR_DEF  = 40;
  localparam int unsigned CALM_HYST_DEF = 8;

  // Score carries one extra bit: the average of cry + heart never exceeds 2*(2**SENS_W-1).
  function automatic int unsigned score_width(input int unsigned sens_w);
    return sens_w + 1;
  endfunction

endpackage

// File: rtl/rock_avg_window.sv
// Settle timer plus windowed averaging of the cry and heart-rate samples.
module rock_avg_window
  import rock_pkg::*;
#(
  parameter int unsigned SENS_W     = 8,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              settle_en,
  input  logic              meas_en,
  input  logic              sample_valid,
  input  logic [SENS_W-1:0] cry,
  input  logic [SENS_W-1:0] hart,
  output logic              settle_done_c,
  output logic              win_done_c,
  output logic [SENS_W:0]   win_score_c
);

  localparam int unsigned SCORE_W = score_width(SENS_W);
  localparam int unsigned SUM_W   = SENS_W + AVG_LOG2 + 1;
  localparam int unsigned AVG_N   = 1 << AVG_LOG2;
  localparam int unsigned SCNT_W  = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam int unsigned NCNT_W  = AVG_LOG2 + 1;

  logic [SCNT_W-1:0] settle_cnt_q;
  logic [NCNT_W-1:0] samp_cnt_q;
  logic [SUM_W-1:0]  sum_cry_q;
  logic [SUM_W-1:0]  sum_hart_q;
  logic [SUM_W-1:0]  total_c;
  logic              take_c;

  assign settle_done_c = settle_en && (settle_cnt_q == SCNT_W'(SETTLE_CYC - 1));
  assign take_c        = meas_en && sample_valid;
  assign win_done_c    = take_c && (samp_cnt_q == NCNT_W'(AVG_N - 1));
  assign total_c       = sum_cry_q + sum_hart_q;
  assign win_score_c   = SCORE_W'(total_c >> AVG_LOG2);

  // Settle timer runs only while settling and restarts on every entry
  always_ff @(posedge clk) begin
    if (reset || clr || !settle_en || settle_done_c) begin
      settle_cnt_q <= '0;
    end else begin
      settle_cnt_q <= settle_cnt_q + SCNT_W'(1);
    end
  end

  // Window accumulator; sums stay valid through DECIDE and are cleared by clr
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sum_cry_q  <= '0;
      sum_hart_q <= '0;
      samp_cnt_q <= '0;
    end else if (take_c) begin
      sum_cry_q  <= sum_cry_q + SUM_W'(cry);
      sum_hart_q <= sum_hart_q + SUM_W'(hart);
      samp_cnt_q <= win_done_c ? '0 : samp_cnt_q + NCNT_W'(1);
    end
  end

endmodule

// File: rtl/rock_controller_gen.sv
// Hill-climbing rocking controller: averages stress, steps A/F to minimise it,
// and holds A/F with hysteresis once calm.
// Optional macro ROCK_RAMP_EN: A/F ramp 1 LSB per clock toward the target.
module rock_controller_gen
  import rock_pkg::*;
#(
  parameter int unsigned SENS_W     = 8,
  parameter int unsigned AF_W       = 4,
  parameter int unsigned AVG_LOG2   = 2,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned STEP       = 1,
  parameter int unsigned CALM_THR   = CALM_THR_DEF,
  parameter int unsigned CALM_HYST  = CALM_HYST_DEF,
  parameter int unsigned A_INIT     = 8,
  parameter int unsigned F_INIT     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sample_valid,
  input  logic [SENS_W-1:0] huilVolume,
  input  logic [SENS_W-1:0] hartRitme,
  output logic [AF_W-1:0]   A,
  output logic [AF_W-1:0]   F,
  output logic              calm,
  output logic [SENS_W:0]   score,
  output logic              step_pulse
);

  localparam int unsigned        SCORE_W = score_width(SENS_W);
  localparam logic [SCORE_W-1:0] THR_V   = SCORE_W'(CALM_THR);
  localparam logic [SCORE_W-1:0] EXIT_V  = SCORE_W'(CALM_THR + CALM_HYST);
  localparam logic [AF_W-1:0]    STEP_V  = AF_W'(STEP);
  localparam logic [AF_W-1:0]    MAX_V   = {AF_W{1'b1}};

  state_t             state_q, state_n;
  axis_t              axis_q, axis_n, step_axis_c;
  dir_t               dir_q, dir_n, step_dir_c, dir_out_c;
  logic [SCORE_W-1:0] best_q, best_n, score_q, score_n, win_score_c;
  logic [AF_W-1:0]    a_tgt_q, a_tgt_n, f_tgt_q, f_tgt_n, cur_c, nxt_c;
  logic               calm_q, calm_n, step_q, step_n;
  logic               settle_en_c, meas_en_c, clr_c, improve_c;
  logic               settle_done_c, win_done_c, ramp_idle_c;

  assign settle_en_c = enable && (state_q == ST_SETTLE) && ramp_idle_c;
  assign meas_en_c   = enable && ((state_q == ST_MEASURE) || (state_q == ST_HOLD));
  assign clr_c       = !enable || (state_q == ST_DECIDE);

  rock_avg_window #(
    .SENS_W    (SENS_W),
    .AVG_LOG2  (AVG_LOG2),
    .SETTLE_CYC(SETTLE_CYC)
  ) u_avg (
    .clk          (clk),
    .reset        (reset),
    .clr          (clr_c),
    .settle_en    (settle_en_c),
    .meas_en      (meas_en_c),
    .sample_valid (sample_valid),
    .cry          (huilVolume),
    .hart         (hartRitme),
    .settle_done_c(settle_done_c),
    .win_done_c   (win_done_c),
    .win_score_c  (win_score_c)
  );

  // Keep searching the same way on improvement, otherwise swap axis and reverse
  assign improve_c   = win_score_c < best_q;
  assign step_axis_c = improve_c ? axis_q : ((axis_q == AXIS_A) ? AXIS_F : AXIS_A);
  assign step_dir_c  = improve_c ? dir_q  : ((dir_q == DIR_UP) ? DIR_DOWN : DIR_UP);

  // Saturating step; bounces off 0 / max so a limit never repeats on consecutive steps
  always_comb begin
    cur_c     = (step_axis_c == AXIS_A) ? a_tgt_q : f_tgt_q;
    nxt_c     = cur_c;
    dir_out_c = step_dir_c;
    if (step_dir_c == DIR_UP) begin
      if (cur_c > MAX_V - STEP_V) begin
        nxt_c     = cur_c - STEP_V;
        dir_out_c = DIR_DOWN;
      end else begin
        nxt_c = cur_c + STEP_V;
      end
    end else begin
      if (cur_c < STEP_V) begin
        nxt_c     = cur_c + STEP_V;
        dir_out_c = DIR_UP;
      end else begin
        nxt_c = cur_c - STEP_V;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state and search decisions
  always_comb begin
    state_n = state_q;
    axis_n  = axis_q;
    dir_n   = dir_q;
    best_n  = best_q;
    score_n = score_q;
    a_tgt_n = a_tgt_q;
    f_tgt_n = f_tgt_q;
    calm_n  = calm_q;
    step_n  = 1'b0;
    if (!enable) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_n = ST_SETTLE;
        ST_SETTLE:  if (settle_done_c) state_n = ST_MEASURE;
        ST_MEASURE,
        ST_HOLD:    if (win_done_c) state_n = ST_DECIDE;
        ST_DECIDE: begin
          score_n = win_score_c;
          if (calm_q) begin
            if (win_score_c > EXIT_V) begin
              calm_n  = 1'b0;
              best_n  = '1;
              state_n = ST_SETTLE;
            end else begin
              state_n = ST_HOLD;
            end
          end else if (win_score_c < THR_V) begin
            calm_n  = 1'b1;
            state_n = ST_HOLD;
          end else begin
            if (improve_c) best_n = win_score_c;
            axis_n = step_axis_c;
            dir_n  = dir_out_c;
            if (step_axis_c == AXIS_A) a_tgt_n = nxt_c;
            else                       f_tgt_n = nxt_c;
            step_n  = 1'b1;
            state_n = ST_SETTLE;
          end
        end
        default:    state_n = ST_IDLE;
      endcase
    end
  end

  // Search registers and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      axis_q  <= AXIS_F;
      dir_q   <= DIR_UP;
      best_q  <= '1;
      score_q <= '0;
      a_tgt_q <= AF_W'(A_INIT);
      f_tgt_q <= AF_W'(F_INIT);
      calm_q  <= 1'b0;
      step_q  <= 1'b0;
    end else begin
      axis_q  <= axis_n;
      dir_q   <= dir_n;
      best_q  <= best_n;
      score_q <= score_n;
      a_tgt_q <= a_tgt_n;
      f_tgt_q <= f_tgt_n;
      calm_q  <= calm_n;
      step_q  <= step_n;
    end
  end

  assign calm  = calm_q;
  assign score = score_q;

`ifdef ROCK_RAMP_EN
  logic [AF_W-1:0] a_out_q, f_out_q, a_ramp_c, f_ramp_c;
  logic            ramp_pulse_q;

  // One LSB per clock toward the target
  always_comb begin
    a_ramp_c = a_out_q;
    f_ramp_c = f_out_q;
    if (a_out_q < a_tgt_q)      a_ramp_c = a_out_q + AF_W'(1);
    else if (a_out_q > a_tgt_q) a_ramp_c = a_out_q - AF_W'(1);
    if (f_out_q < f_tgt_q)      f_ramp_c = f_out_q + AF_W'(1);
    else if (f_out_q > f_tgt_q) f_ramp_c = f_out_q - AF_W'(1);
  end

  assign ramp_idle_c = (a_out_q == a_tgt_q) && (f_out_q == f_tgt_q);

  // Ramp registers; the strobe marks arrival at the target
  always_ff @(posedge clk) begin
    if (reset) begin
      a_out_q      <= AF_W'(A_INIT);
      f_out_q      <= AF_W'(F_INIT);
      ramp_pulse_q <= 1'b0;
    end else if (enable) begin
      a_out_q      <= a_ramp_c;
      f_out_q      <= f_ramp_c;
      ramp_pulse_q <= !ramp_idle_c && (a_ramp_c == a_tgt_q) && (f_ramp_c == f_tgt_q);
    end else begin
      ramp_pulse_q <= 1'b0;
    end
  end

  assign A          = a_out_q;
  assign F          = f_out_q;
  assign step_pulse = ramp_pulse_q;
`else
  assign ramp_idle_c = 1'b1;
  assign A           = a_tgt_q;
  assign F           = f_tgt_q;
  assign step_pulse  = step_q;
`endif

endmodule

// File: tb/tb_rock_controller_gen.sv
// Directed bench for rock_controller_gen with default parameters.
module tb_rock_controller_gen;

  logic       clk = 1'b0;
  logic       reset, enable, sample_valid;
  logic [7:0] huilVolume, hartRitme;
  logic [3:0] A, F;
  logic       calm, step_pulse;
  logic [8:0] score;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  rock_controller_gen dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .sample_valid(sample_valid),
    .huilVolume  (huilVolume),
    .hartRitme   (hartRitme),
    .A           (A),
    .F           (F),
    .calm        (calm),
    .score       (score),
    .step_pulse  (step_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold one sample value and wait (bounded) for the next step strobe; lat=0 on timeout
  task automatic run_window(input logic [7:0] c, input logic [7:0] h, output int lat);
    huilVolume   = c;
    hartRitme    = h;
    sample_valid = 1'b1;
    lat          = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (step_pulse) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; sample_valid = 1'b0; huilVolume = '0; hartRitme = '0;
    repeat (3) tick();
    n_tests++; if (A !== 4'd8) begin n_fail++; $display("FAIL reset_A got %0d exp 8", A); end
    n_tests++; if (F !== 4'd8) begin n_fail++; $display("FAIL reset_F got %0d exp 8", F); end
    n_tests++; if (calm !== 1'b0) begin n_fail++; $display("FAIL reset_calm got %0d exp 0", calm); end
    n_tests++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_step got %0d exp 0", step_pulse); end
    n_tests++; if (score !== 9'd0) begin n_fail++; $display("FAIL reset_score got %0d exp 0", score); end
  endtask

  task automatic test_first_eval();
    int lat;
    reset = 1'b0;
    run_window(8'd50, 8'd50, lat);
    n_tests++; if (lat !== 22) begin n_fail++; $display("FAIL first_lat got %0d exp 22", lat); end
    n_tests++; if (score !== 9'd100) begin n_fail++; $display("FAIL first_score got %0d exp 100", score); end
    n_tests++; if (F !== 4'd9) begin n_fail++; $display("FAIL first_F got %0d exp 9", F); end
    n_tests++; if (A !== 4'd8) begin n_fail++; $display("FAIL first_A got %0d exp 8", A); end
    tick();
    n_tests++; if (step_pulse !== 1'b0) begin n_fail++; $display("FAIL first_pulse_width got %0d exp 0", step_pulse); end
  endtask

  task automatic test_no_improve();
    int lat;
    run_window(8'd50, 8'd50, lat);
    n_tests++; if (lat !== 20) begin n_fail++; $display("FAIL noimp_lat got %0d exp 20", lat); end
    n_tests++; if (A !== 4'd7) begin n_fail++; $display("FAIL noimp_A got %0d exp 7", A); end
    n_tests++; if (F !== 4'd9) begin n_fail++; $display("FAIL noimp_F got %0d exp 9", F); end
    n_tests++; if (score !== 9'd100) begin n_fail++; $display("FAIL noimp_score got %0d exp 100", score); end
  endtask

  // Swap back to F going up, climb to 15, then bounce off the top
  task automatic test_saturation();
    int lat;
    logic [7:0] hv [8] = '{8'd50, 8'd49, 8'd48, 8'd47, 8'd46, 8'd45, 8'd44, 8'd43};
    logic [3:0] fx [8] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd14, 4'd13};
    for (int k = 0; k < 8; k++) begin
      run_window(8'd50, hv[k], lat);
      n_tests++; if (lat !== 21) begin n_fail++; $display("FAIL sat_lat[%0d] got %0d exp 21", k, lat); end
      n_tests++; if (F !== fx[k]) begin n_fail++; $display("FAIL sat_F[%0d] got %0d exp %0d", k, F, fx[k]); end
    end
    n_tests++; if (A !== 4'd7) begin n_fail++; $display("FAIL sat_A got %0d exp 7", A); end
  endtask

  task automatic test_calm_hyst();
    int   lat;
    logic saw;
    huilVolume = 8'd10; hartRitme = 8'd20; sample_valid = 1'b1;
    lat = 0; saw = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (step_pulse) saw = 1'b1;
      if (calm) begin lat = i; break; end
    end
    n_tests++; if (lat !== 21) begin n_fail++; $display("FAIL calm_lat got %0d exp 21", lat); end
    n_tests++; if (score !== 9'd30) begin n_fail++; $display("FAIL calm_score got %0d exp 30", score); end
    n_tests++; if (saw !== 1'b0) begin n_fail++; $display("FAIL calm_nostep got %0d exp 0", saw); end
    n_tests++; if (F !== 4'd13 || A !== 4'd7) begin n_fail++; $display("FAIL calm_AF got %0d/%0d exp 7/13", A, F); end
    huilVolume = 8'd20; hartRitme = 8'd25;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step_pulse) saw = 1'b1;
      if (score == 9'd45) begin lat = i; break; end
    end
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL hold45_lat got %0d exp 5", lat); end
    n_tests++; if (calm !== 1'b1) begin n_fail++; $display("FAIL hold45_calm got %0d exp 1", calm); end
    n_tests++; if (saw !== 1'b0) begin n_fail++; $display("FAIL hold45_nostep got %0d exp 0", saw); end
    huilVolume = 8'd24; hartRitme = 8'd25;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!calm) begin lat = i; break; end
    end
    n_tests++; if (lat !== 5) begin n_fail++; $display("FAIL exit_lat got %0d exp 5", lat); end
    n_tests++; if (score !== 9'd49) begin n_fail++; $display("FAIL exit_score got %0d exp 49", score); end
    run_window(8'd30, 8'd30, lat);
    n_tests++; if (lat !== 21) begin n_fail++; $display("FAIL resume_lat got %0d exp 21", lat); end
    n_tests++; if (F !== 4'd12) begin n_fail++; $display("FAIL resume_F got %0d exp 12", F); end
    n_tests++; if (score !== 9'd60) begin n_fail++; $display("FAIL resume_score got %0d exp 60", score); end
  endtask

  task automatic test_enable_drop();
    int   lat;
    logic saw;
    huilVolume = 8'd50; hartRitme = 8'd40; sample_valid = 1'b1;
    repeat (18) tick();
    enable = 1'b0; saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (step_pulse) saw = 1'b1;
    end
    n_tests++; if (A !== 4'd7 || F !== 4'd12) begin n_fail++; $display("FAIL endrop_AF got %0d/%0d exp 7/12", A, F); end
    n_tests++; if (score !== 9'd60) begin n_fail++; $display("FAIL endrop_score got %0d exp 60", score); end
    n_tests++; if (saw !== 1'b0) begin n_fail++; $display("FAIL endrop_nostep got %0d exp 0", saw); end
    enable = 1'b1;
    run_window(8'd50, 8'd30, lat);
    n_tests++; if (lat !== 22) begin n_fail++; $display("FAIL reen_lat got %0d exp 22", lat); end
    n_tests++; if (score !== 9'd80) begin n_fail++; $display("FAIL reen_score got %0d exp 80", score); end
    n_tests++; if (A !== 4'd8 || F !== 4'd12) begin n_fail++; $display("FAIL reen_AF got %0d/%0d exp 8/12", A, F); end
  endtask

  // Large samples during settle must not enter the window; last window sums to 361 -> 90
  task automatic test_settle_ignore();
    int lat;
    logic [7:0] cv [4] = '{8'd10, 8'd31, 8'd50, 8'd70};
    logic [7:0] hv [4] = '{8'd20, 8'd40, 8'd60, 8'd80};
    huilVolume = 8'd200; hartRitme = 8'd200; sample_valid = 1'b1;
    repeat (16) tick();
    for (int k = 0; k < 4; k++) begin
      huilVolume = cv[k]; hartRitme = hv[k];
      tick();
    end
    sample_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (step_pulse) begin lat = i; break; end
    end
    n_tests++; if (lat !== 1) begin n_fail++; $display("FAIL settle_lat got %0d exp 1", lat); end
    n_tests++; if (score !== 9'd90) begin n_fail++; $display("FAIL settle_score got %0d exp 90", score); end
    n_tests++; if (F !== 4'd11 || A !== 4'd8) begin n_fail++; $display("FAIL settle_AF got %0d/%0d exp 8/11", A, F); end
  endtask

  task automatic test_reset_mid();
    int lat;
    huilVolume = 8'd100; hartRitme = 8'd100; sample_valid = 1'b1;
    repeat (18) tick();
    reset = 1'b1;
    tick();
    n_tests++; if (A !== 4'd8 || F !== 4'd8) begin n_fail++; $display("FAIL rstmid_AF got %0d/%0d exp 8/8", A, F); end
    n_tests++; if (score !== 9'd0) begin n_fail++; $display("FAIL rstmid_score got %0d exp 0", score); end
    n_tests++; if (calm !== 1'b0 || step_pulse !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags got %0d/%0d exp 0/0", calm, step_pulse); end
    reset = 1'b0;
    run_window(8'd50, 8'd50, lat);
    n_tests++; if (lat !== 22) begin n_fail++; $display("FAIL rstmid_lat got %0d exp 22", lat); end
    n_tests++; if (score !== 9'd100) begin n_fail++; $display("FAIL rstmid_wscore got %0d exp 100", score); end
    n_tests++; if (F !== 4'd9 || A !== 4'd8) begin n_fail++; $display("FAIL rstmid_step got %0d/%0d exp 8/9", A, F); end
  endtask

  initial begin
    test_reset();
    test_first_eval();
    test_no_improve();
    test_saturation();
    test_calm_hyst();
    test_enable_drop();
    test_settle_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
